// File: rtl/seq_alu_pkg.sv
// Shared types and constants for seq_alu.
//   op_t    : 4-bit operation code (10..15 reserved, not enumerated)
//   state_t : control FSM states
//   Flag*   : bit positions of C/Z/V/N inside the packed flag register
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpAdc = 4'd2,
    OpSbc = 4'd3,
    OpAnd = 4'd4,
    OpOr  = 4'd5,
    OpXor = 4'd6,
    OpShl = 4'd7,
    OpShr = 4'd8,
    OpAsr = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StShift
  } state_t;

  localparam int unsigned FlagC = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagV = 1;
  localparam int unsigned FlagN = 0;

  // Subtract-type ops feed the adder with the inverted B operand.
  function automatic logic is_sub(op_t op);
    return (op == OpSub) || (op == OpSbc);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor.
//   a, b     : operands
//   sub      : invert b (two's-complement subtract when cin=1)
//   cin      : carry in
//   sum      : low WIDTH bits of a + b' + cin
//   carry    : bit WIDTH of the internal sum (no-borrow for subtract)
//   overflow : signed overflow of the effective addition
module alu_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff    = sub ? ~b : b;
  assign full     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  assign sum      = full[WIDTH-1:0];
  assign carry    = full[WIDTH];
  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/seq_alu.sv
// Registered multi-cycle ALU with start/busy/done handshake.
//   clk, rst        : clock, synchronous active-high reset
//   start, op       : request and opcode (accepted only while busy=0)
//   port_a, port_b  : operands; port_b[SHAMT_W-1:0] is the shift amount
//   output_port     : registered result, held between operations
//   busy            : operation in progress (EXEC or SHIFT)
//   done            : one-cycle pulse when result/flags are committed
//   carry, zero, overflow, negative : registered flags
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  output logic [WIDTH-1:0] output_port,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             negative
);

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d;

  logic [SHAMT_W-1:0] amt;
  logic               as_cin;
  logic [WIDTH-1:0]   as_sum;
  logic               as_carry;
  logic               as_ovf;
  logic [WIDTH-1:0]   sh_next;
  logic               sh_out;

  assign amt = b_q[SHAMT_W-1:0];

  // Carry flag is stable between acceptance and EXEC, so ADC/SBC read it directly.
  always_comb begin
    as_cin = 1'b0;
    case (op_q)
      OpSub:        as_cin = 1'b1;
      OpAdc, OpSbc: as_cin = flags_q[FlagC];
      default:      as_cin = 1'b0;
    endcase
  end

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a        (a_q),
    .b        (b_q),
    .sub      (is_sub(op_q)),
    .cin      (as_cin),
    .sum      (as_sum),
    .carry    (as_carry),
    .overflow (as_ovf)
  );

  // One-bit shift step and the bit it drops.
  always_comb begin
    sh_next = sh_q;
    sh_out  = 1'b0;
    case (op_q)
      OpShl: begin
        sh_next = {sh_q[WIDTH-2:0], 1'b0};
        sh_out  = sh_q[WIDTH-1];
      end
      OpShr: begin
        sh_next = {1'b0, sh_q[WIDTH-1:1]};
        sh_out  = sh_q[0];
      end
      default: begin
        sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        sh_out  = sh_q[0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op_t'(op);
          a_d     = port_a;
          b_d     = port_b;
          state_d = StExec;
        end
      end

      StExec: begin
        state_d = StIdle;
        done_d  = 1'b1;
        case (op_q)
          OpAdd, OpSub, OpAdc, OpSbc: begin
            res_d          = as_sum;
            flags_d[FlagC] = as_carry;
            flags_d[FlagV] = as_ovf;
            flags_d[FlagZ] = (as_sum == '0);
            flags_d[FlagN] = as_sum[WIDTH-1];
          end
          OpAnd, OpOr, OpXor: begin
            res_d = (op_q == OpAnd) ? (a_q & b_q) :
                    (op_q == OpOr)  ? (a_q | b_q) : (a_q ^ b_q);
            flags_d[FlagV] = 1'b0;
            flags_d[FlagZ] = (res_d == '0);
            flags_d[FlagN] = res_d[WIDTH-1];
          end
          OpShl, OpShr, OpAsr: begin
            if (amt == '0) begin
              // Zero-amount shift passes A through; carry keeps its value.
              res_d          = a_q;
              flags_d[FlagV] = 1'b0;
              flags_d[FlagZ] = (a_q == '0);
              flags_d[FlagN] = a_q[WIDTH-1];
            end else begin
              sh_d    = a_q;
              cnt_d   = amt;
              state_d = StShift;
              done_d  = 1'b0;
            end
          end
          default: ; // reserved: pulse done only
        endcase
      end

      StShift: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          res_d          = sh_next;
          flags_d[FlagC] = sh_out;
          flags_d[FlagV] = 1'b0;
          flags_d[FlagZ] = (sh_next == '0);
          flags_d[FlagN] = sh_next[WIDTH-1];
          done_d         = 1'b1;
          state_d        = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign output_port = res_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign carry       = flags_q[FlagC];
  assign zero        = flags_q[FlagZ];
  assign overflow    = flags_q[FlagV];
  assign negative    = flags_q[FlagN];

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU for the datapath. It performs add/subtract with carry chaining, bitwise logic, and multi-cycle shifts under a start/busy/done handshake. Result and a four-bit flag register (C, Z, V, N) are held between operations, so the control sequencer can branch on flags and chain multi-word arithmetic. It sits between the A/B registers and the bus in place of the purely combinational adder.

## Interface
Parameters:
- WIDTH, 8, operand/result width; power of two, ≥ 4
- SHAMT_W, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  request an operation; accepted only when busy=0
- op  in  4  operation code (seq_alu_pkg::op_t)
- port_a  in  WIDTH  operand A
- port_b  in  WIDTH  operand B; for shifts, port_b[SHAMT_W-1:0] is the shift amount
- output_port  out  WIDTH  registered result
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when output_port/flags are updated
- carry, zero, overflow, negative  out  1 each  registered flags

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 ADC, 3 SBC
  - 4 AND, 5 OR, 6 XOR
  - 7 SHL, 8 SHR, 9 ASR
  - 10–15 reserved
- On accepted start, op, port_a and port_b are latched. Later input changes have no effect until done.
- Arithmetic (WIDTH+1-bit internal sum):
  - ADD: a+b
  - ADC: a+b+C
  - SUB: a+~b+1
  - SBC: a+~b+C
  - carry = bit WIDTH of the sum. For SUB/SBC, carry=1 means no borrow (a ≥ b for SUB).
  - overflow = (a[MSB]==b'[MSB]) && (r[MSB]!=a[MSB]), where b' = b for add and ~b for subtract.
- Logic ops: overflow cleared, carry unchanged.
- Shifts: performed one bit per cycle.
  - SHL: zero fill.
  - SHR: zero fill.
  - ASR: MSB replicated.
  - carry = last bit shifted out; unchanged if amount=0. overflow cleared.
- zero = (result==0); negative = result[MSB]. Both are updated for every non-reserved op.
- Reserved op: done pulses, output_port and all flags unchanged.
- FSM (seq_alu_pkg::state_t):
  - IDLE: start → EXEC.
  - EXEC: single-cycle ops and zero-amount shifts → commit result, go to IDLE. Nonzero shifts → load counter = amount, go to SHIFT.
  - SHIFT: shift one bit and decrement; at counter==1 commit and go to IDLE.
- busy=1 in EXEC and SHIFT. start while busy is ignored (not queued).
- rst at any state:
  - go to IDLE
  - output_port=0, all flags=0, busy=0, done=0, counter=0
  - any in-flight operation is discarded.

## Timing
- start accepted at edge T; EXEC occupies cycle T+1; busy=1 from T+1.
- Single-cycle op: output_port, flags and done valid from edge T+2 (latency 2 edges). busy=0 in the done cycle.
- Shift by n>0: done from edge T+2+n−1+1 = T+n+2. busy high for n+1 cycles.
- start may be reasserted in the done cycle; it is accepted (busy=0). Back-to-back single-cycle ops therefore give one result every 2 cycles.
- done high for exactly one cycle per accepted start.
- Outputs hold between operations.
- ADC/SBC use the carry flag value at the accepted start, including a carry produced by an op whose done coincides with the start edge.

## Structure
- seq_alu_pkg: op_t enum (4-bit), state_t enum (IDLE, EXEC, SHIFT), flag index constants.
- Sub-module alu_addsub: combinational WIDTH-parametrised adder with sub and cin inputs; outputs sum, carry, overflow. Instantiated once.
- Shift register, counter, FSM and flag register live in seq_alu.

## Test plan
- After rst: all outputs 0. ADD 0x7F+0x01 → output_port=0x80, N=1, V=1, C=0, Z=0; done exactly 2 edges after start, single pulse.
- SUB 0x05−0x05 → 0x00, Z=1, C=1, V=0. Then SUB 0x00−0x01 → 0xFF, C=0, N=1, V=0. Then SUB 0x80−0x01 → 0x7F, V=1.
- Carry chaining: ADD 0xFF+0x01 → 0x00, C=1, Z=1. Then ADC 0x00+0x00 → 0x01, C=0. Then SBC 0x10−0x00 with C=0 → 0x0F.
- Shifts:
  - SHL 0x81 by 3 → busy 4 cycles; 0x08, C=0.
  - ASR 0x80 by 7 → 0xFF, N=1.
  - SHR 0x01 by 1 → 0x00, C=1, Z=1.
  - SHL by 0 → result=a, C unchanged, done after 2 edges.
- Handshake/robustness:
  - start pulses during SHL by 5 are ignored; exactly one done.
  - rst asserted in SHIFT → next edge all outputs 0, IDLE; a start the following cycle completes normally.
- Logic ops and reserved op:
  - AND 0xF0&0x3C → 0x30, C unchanged, V=0.
  - XOR 0xAA^0xAA → Z=1.
  - op=12 → done pulses, output_port and flags unchanged.
